// File: rtl/fpu_pkg.sv
// Shared FP32 field layout, state encoding and bundle types
// for the floating-point display path.
package fpu_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    CONVERT,
    DONE
  } state_t;

endpackage

// File: rtl/fp32_to_uint_round.sv
// FP32 to unsigned integer magnitude, round half away from zero,
// saturating at MAXV; also flags Inf/NaN and reports sign.
module fp32_to_uint_round
  import fpu_pkg::*;
#(
  parameter int BW   = 14,
  parameter int MAXV = 9999
) (
  input  fp32_t          fp,
  output logic [BW-1:0]  mag,
  output logic           sat,
  output logic           neg
);

  logic [63:0] sig;
  logic [63:0] rnd;
  logic [5:0]  sh;
  logic        half;
  int          e;

  always_comb begin
    sig  = {40'd0, 1'b1, fp.mant};
    e    = int'({24'd0, fp.exp}) - EXP_BIAS;
    rnd  = '0;
    sh   = '0;
    half = 1'b0;
    mag  = '0;
    sat  = 1'b0;
    neg  = 1'b0;
    if (fp.exp == EXP_SPECIAL) begin
      // Inf keeps its sign, NaN is shown as positive
      mag = BW'(MAXV);
      sat = 1'b1;
      neg = fp.sign && (fp.mant == '0);
    end else begin
      if (fp.exp == '0) begin
        mag = '0;
      end else if (e < -1) begin
        mag = '0;
      end else if (e == -1) begin
        mag = BW'(1);
      end else if (e >= BW) begin
        mag = BW'(MAXV);
        sat = 1'b1;
      end else begin
        if (e >= MANT_W) begin
          rnd = sig << 6'(e - MANT_W);
        end else begin
          sh   = 6'(MANT_W - e);
          half = sig[sh - 6'd1];
          rnd  = (sig >> sh) + 64'(half);
        end
        if (rnd > 64'(MAXV)) begin
          mag = BW'(MAXV);
          sat = 1'b1;
        end else begin
          mag = rnd[BW-1:0];
        end
      end
      neg = fp.sign && (mag != '0);
    end
  end

endmodule

// File: rtl/fp32_to_bcd_seq.sv
// Sequential FP32 to signed packed-BCD converter:
// one rounding cycle followed by a fixed-length double-dabble.
module fp32_to_bcd_seq
  import fpu_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           fp_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  sat
);

  localparam int BW   = $clog2(10**DIGITS);
  localparam int MAXV = 10**DIGITS - 1;
  localparam int CW   = $clog2(BW + 1);
  localparam int NW   = 4 * DIGITS;

  state_t state, state_nx;

  fp32_t          fp_q;
  logic [BW-1:0]  mag;
  logic           r_sat;
  logic           r_neg;
  logic [BW-1:0]  bin;
  logic [NW-1:0]  bcd;
  logic [CW-1:0]  cnt;
  logic           sat_q;
  logic           neg_q;
  logic [NW-1:0]  bcd_adj;
  logic [NW+BW-1:0] shifted;
  logic           last;

  fp32_to_uint_round #(
    .BW   (BW),
    .MAXV (MAXV)
  ) u_round (
    .fp  (fp_q),
    .mag (mag),
    .sat (r_sat),
    .neg (r_neg)
  );

  assign last = (cnt == CW'(BW - 1));

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ALIGN;
      end
      ALIGN:   state_nx = CONVERT;
      CONVERT: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_q    <= '0;
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      sat_q   <= 1'b0;
      neg_q   <= 1'b0;
      bcd_out <= '0;
      neg     <= 1'b0;
      sat     <= 1'b0;
    end else begin
      if (state == IDLE && in_valid)
        fp_q <= fp_in;
      if (state == ALIGN) begin
        bin   <= mag;
        bcd   <= '0;
        cnt   <= '0;
        sat_q <= r_sat;
        neg_q <= r_neg;
      end
      if (state == CONVERT) begin
        {bcd, bin} <= shifted;
        cnt        <= cnt + CW'(1);
        // final shift lands straight in the visible result
        if (last) begin
          bcd_out <= shifted[NW+BW-1:BW];
          neg     <= neg_q;
          sat     <= sat_q;
        end
      end
    end
  end

endmodule
